ncpu32k_rr_arbiter: RTL
=======================

Name: ncpu32k_rr_arbiter

Overview:
- Parametrised round-robin arbiter with burst locking. Successor to the combinational priority one-hot cell.
- Arbitrates N requesters onto one shared resource, e.g. I/D-cache refill ports onto the bus master.
- Grant is registered and held stable until the winner's transfer completes (ACK with LAST), so multi-beat bursts are never interleaved.
- Fairness: a rotating priority pointer replaces fixed LSB-first priority.

Parameters:
- N, 4: number of requesters, 1..32.
- POLARITY_REQ, 1: nonzero means REQ is active high; 0 means active low.
- POLARITY_GNT, 1: nonzero means GNT is active high; 0 means active low.
- IW, derived: max(1, clog2(N)). Width of GNT_IDX. Not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous reset, active low.
- REQ  input  N  per-channel request, polarity set by POLARITY_REQ.
- ACK  input  1  resource accepted one beat of the granted channel this cycle.
- LAST  input  1  accepted beat is the final one of the burst; only qualified by ACK.
- GNT  output  N  one-hot grant, registered, polarity set by POLARITY_GNT.
- GNT_VALID  output  1  a grant is outstanding (active high).
- GNT_IDX  output  IW  binary index of the granted channel; 0 when GNT_VALID=0.

Behaviour:
- Reset, asynchronous, while rst_n=0:
  - GNT = all inactive (all 0 for high polarity, all 1 for low polarity).
  - GNT_VALID=0, GNT_IDX=0, internal ptr=0, state IDLE.
- Internally REQ is normalised to active-high r[]. All logic is active high; GNT is inverted at the output if POLARITY_GNT=0.
- Selection function sel(r, ptr): the first set bit of r scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1, i.e. with wrap-around.
  - Implemented as a double-width masked priority one-hot: (r & mask_ge_ptr) first, else r unmasked.
- State IDLE:
  - If any r set at a rising edge: GNT <= onehot(sel), GNT_IDX <= sel, GNT_VALID <= 1, go to BUSY.
  - Latency: REQ asserted in cycle t gives GNT visible in cycle t+1.
  - ACK and LAST are ignored in IDLE.
- State BUSY:
  - GNT, GNT_IDX and the winner are frozen. Other requests are not preempted.
  - ACK with LAST=0: no change.
  - ACK&LAST, or the winner's r deasserted (abort): release. ptr <= (GNT_IDX+1) mod N.
    - In the same edge, re-arbitrate among current r using the new pointer value.
    - If any r (including the just-released channel) is set: new grant, stay BUSY. Back-to-back, no bubble.
    - Else: GNT inactive, GNT_VALID=0, GNT_IDX=0, go to IDLE.
  - If ACK&LAST and the winner deasserts in the same cycle: treated as one release; ptr advances once.
- ptr changes only on release. It wraps from N-1 to 0.
- N=1: the only channel is always selected; ptr stays 0.
- Invariants:
  - GNT has at most one active bit; it is all inactive exactly when GNT_VALID=0.
  - GNT_IDX equals the position of the active GNT bit.
- No combinational path from REQ, ACK or LAST to any output.
- Reset asserted mid-burst: outputs are immediately inactive and ptr returns to 0. After reset release, arbitration restarts from channel 0.

Test Plan:
- Reset/idle (N=4): hold rst_n=0, then release with REQ=0000 -> GNT=0000, GNT_VALID=0, GNT_IDX=0 for 10 cycles; ACK/LAST pulses have no effect.
- Single request: REQ=0100 at cycle 3 -> GNT=0100, GNT_IDX=2 at cycle 4. ACK&LAST at cycle 6 -> GNT=0000 at cycle 7; ptr=3.
- Round-robin rotation: REQ=1111 held, ACK&LAST every 2nd cycle -> grant order 0,1,2,3,0 with no idle cycle between grants.
- Burst lock: grant to ch1. REQ=0011 held, ACK with LAST=0 for 3 cycles, then ACK&LAST -> GNT stays 0010 throughout; next grant is ch0 (wrap: ptr=2, no request at 2 or 3).
- Abort and wrap: grant ch3. Drop REQ[3] without ACK while REQ=0001 -> next cycle GNT=0001, GNT_IDX=0 (ptr wrapped 3->0).
- Polarity: POLARITY_REQ=0, POLARITY_GNT=0, REQ=1101 (ch1 active) -> GNT=1101, GNT_IDX=1. Idle and reset state are GNT=1111.
- Reset mid-burst: assert rst_n=0 during BUSY on ch2 -> outputs inactive asynchronously. After release with REQ=1111, first grant is ch0.

Source files
------------

// File: rtl/ncpu32k_rr_arbiter_if.sv
// ncpu32k_rr_arbiter_if: request/ack handshake and grant bundle for the round-robin arbiter
interface ncpu32k_rr_arbiter_if #(parameter int N = 4);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  logic [N-1:0]  REQ;
  logic          ACK;
  logic          LAST;
  logic [N-1:0]  GNT;
  logic          GNT_VALID;
  logic [IW-1:0] GNT_IDX;
  modport master (output REQ, ACK, LAST, input GNT, GNT_VALID, GNT_IDX);
  modport slave  (input REQ, ACK, LAST, output GNT, GNT_VALID, GNT_IDX);
endinterface

// File: rtl/ncpu32k_rr_arbiter.sv
// ncpu32k_rr_arbiter: round-robin arbiter with registered grant held until burst end (ACK&LAST) or abort
module ncpu32k_rr_arbiter #(
  parameter int N = 4,
  parameter int POLARITY_REQ = 1,
  parameter int POLARITY_GNT = 1
) (
  input logic clk,
  input logic rst_n,
  ncpu32k_rr_arbiter_if.slave bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0]     state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d, r, mask;
  logic [IW-1:0]  idx_q, idx_d, ptr_q, ptr_d, ptr_nxt, ptr_sel, sel;
  logic [2*N-1:0] dbl;
  logic           found, rel;
  assign r = (POLARITY_REQ != 0) ? bus.REQ : ~bus.REQ;
  // release on completed burst or when the winner drops its request
  assign rel = (state_q == BUSY) && ((bus.ACK && bus.LAST) || !(|(r & gnt_q)));
  assign ptr_nxt = (int'(idx_q) == N - 1) ? '0 : idx_q + 1'b1;
  assign ptr_sel = rel ? ptr_nxt : ptr_q;
  // low half holds requests at or above the pointer, high half the wrapped remainder
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) mask[i] = (i >= int'(ptr_sel));
    dbl = {r, r & mask};
    sel = '0;
    found = 1'b0;
    for (int i = 0; i < 2 * N; i++)
      if (!found && dbl[i]) begin
        found = 1'b1;
        sel = IW'(i % N);
      end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = rel ? ptr_nxt : ptr_q;
    if (state_q == IDLE || rel) begin
      state_d = found ? BUSY : IDLE;
      gnt_d = found ? N'(1) << sel : '0;
      idx_d = found ? sel : '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
    end
  end
  assign bus.GNT = (POLARITY_GNT != 0) ? gnt_q : ~gnt_q;
  assign bus.GNT_VALID = state_q == BUSY;
  assign bus.GNT_IDX = idx_q;
endmodule
